// File: rtl/kf8254_bus_interface_if.sv
// CPU-side pin bundle of the 8253/8254 timer bus front-end.
// The CPU or bench drives the master side; the front-end samples the slave side.
interface kf8254_bus_interface_if;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic [1:0] address;
  logic [7:0] data_bus_in;

  modport master (
    output chip_select_n,
    output read_enable_n,
    output write_enable_n,
    output address,
    output data_bus_in
  );

  modport slave (
    input chip_select_n,
    input read_enable_n,
    input write_enable_n,
    input address,
    input data_bus_in
  );
endinterface

// File: rtl/kf8254_bus_interface.sv
// Bus front-end for the 8253/8254 timer family: samples CPU strobes on the falling clock edge and
// turns completed accesses into one-cycle per-counter strobes and read-back latch pulses.
module kf8254_bus_interface #(
  parameter int unsigned NUM_COUNTERS = 3,
  parameter int unsigned SYNC_STAGES  = 0,
  parameter bit          READBACK_EN  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  kf8254_bus_interface_if.slave   bus,
  output logic [7:0]              internal_data_bus,
  output logic [NUM_COUNTERS-1:0] write_control,
  output logic [NUM_COUNTERS-1:0] write_counter,
  output logic [NUM_COUNTERS-1:0] read_counter,
  output logic [NUM_COUNTERS-1:0] read_done,
  output logic [NUM_COUNTERS-1:0] latch_count,
  output logic [NUM_COUNTERS-1:0] latch_status
);

  localparam int unsigned SampleWidth = 13;
  // Strobes reset to their inactive (high) level, address/data to zero.
  localparam logic [SampleWidth-1:0] SyncResetVal = {3'b111, 10'b0};

  logic [SampleWidth-1:0] pins;
  logic [SampleWidth-1:0] sampled;
  logic                   sync_valid;

  assign pins = {bus.chip_select_n, bus.read_enable_n, bus.write_enable_n, bus.address,
                 bus.data_bus_in};

  if (SYNC_STAGES == 0) begin : g_direct
    assign sampled    = pins;
    assign sync_valid = 1'b1;
  end else begin : g_sync
    logic [SampleWidth-1:0] stage_q [SYNC_STAGES];
    logic [1:0]             fill_q;

    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= SyncResetVal;
        fill_q <= 2'd0;
      end else begin
        stage_q[0] <= pins;
        for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
        if (fill_q != 2'(SYNC_STAGES)) fill_q <= fill_q + 2'd1;
      end
    end

    assign sampled = stage_q[SYNC_STAGES-1];
    // Reset-value samples still in the chain must not count as an idle bus for arming.
    assign sync_valid = (fill_q == 2'(SYNC_STAGES));
  end

  logic       s_cs_n, s_rd_n, s_wr_n;
  logic [1:0] s_addr;
  logic [7:0] s_data;
  logic       wr_act, rd_act;

  assign {s_cs_n, s_rd_n, s_wr_n, s_addr, s_data} = sampled;
  assign wr_act = ~s_wr_n & ~s_cs_n;
  assign rd_act = ~s_rd_n & ~s_cs_n & s_wr_n;

  logic [7:0]              data_q, data_d;
  logic [1:0]              wr_addr_q, wr_addr_d;
  logic [1:0]              rd_addr_q, rd_addr_d;
  logic                    wr_act_q, rd_act_q;
  logic                    armed_q, armed_d;
  logic [1:0]              sc;
  logic [NUM_COUNTERS-1:0] wc_q, wc_d, wcnt_q, wcnt_d, rdc_q, rdc_d;
  logic [NUM_COUNTERS-1:0] done_q, done_d, lc_q, lc_d, ls_q, ls_d;

  always_comb begin
    data_d    = data_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    armed_d   = armed_q | (sync_valid & ~wr_act & ~rd_act);
    sc        = data_q[7:6];
    wc_d      = '0;
    wcnt_d    = '0;
    rdc_d     = '0;
    done_d    = '0;
    lc_d      = '0;
    ls_d      = '0;

    if (wr_act) begin
      data_d    = s_data;
      wr_addr_d = s_addr;
    end
    if (rd_act) rd_addr_d = s_addr;

    if (armed_q) begin
      for (int i = 0; i < int'(NUM_COUNTERS); i++) rdc_d[i] = rd_act & (s_addr == 2'(i));

      // Write end: address and data still hold the values from the last active sample.
      if (wr_act_q && !wr_act) begin
        if (wr_addr_q == 2'b11) begin
          if (sc == 2'b11) begin
            if (READBACK_EN) begin
              for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
                if (data_q[i+1]) begin
                  lc_d[i] = ~data_q[5];
                  ls_d[i] = ~data_q[4];
                end
              end
            end
          end else begin
            for (int i = 0; i < int'(NUM_COUNTERS); i++) wc_d[i] = (sc == 2'(i));
          end
        end else begin
          for (int i = 0; i < int'(NUM_COUNTERS); i++) wcnt_d[i] = (wr_addr_q == 2'(i));
        end
      end

      if (rd_act_q && !rd_act) begin
        for (int i = 0; i < int'(NUM_COUNTERS); i++) done_d[i] = (rd_addr_q == 2'(i));
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      data_q    <= 8'h00;
      wr_addr_q <= 2'b00;
      rd_addr_q <= 2'b00;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      armed_q   <= 1'b0;
      wc_q      <= '0;
      wcnt_q    <= '0;
      rdc_q     <= '0;
      done_q    <= '0;
      lc_q      <= '0;
      ls_q      <= '0;
    end else begin
      data_q    <= data_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_act_q  <= wr_act;
      rd_act_q  <= rd_act;
      armed_q   <= armed_d;
      wc_q      <= wc_d;
      wcnt_q    <= wcnt_d;
      rdc_q     <= rdc_d;
      done_q    <= done_d;
      lc_q      <= lc_d;
      ls_q      <= ls_d;
    end
  end

  assign internal_data_bus = data_q;
  assign write_control     = wc_q;
  assign write_counter     = wcnt_q;
  assign read_counter      = rdc_q;
  assign read_done         = done_q;
  assign latch_count       = lc_q;
  assign latch_status      = ls_q;

endmodule

// File: tb/tb_kf8254_bus_interface.sv
// Bench for kf8254_bus_interface: one bus drives an 8254-style instance (3 counters, no sync)
// and an 8253-style instance (2 counters, 2 sync stages, no read-back); expected events are queued.
module tb_kf8254_bus_interface;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  kf8254_bus_interface_if bus ();

  logic [7:0] a_data, b_data;
  logic [2:0] a_wc, a_wcnt, a_rdc, a_rdd, a_lc, a_ls;
  logic [1:0] b_wc, b_wcnt, b_rdc, b_rdd, b_lc, b_ls;

  kf8254_bus_interface #(
    .NUM_COUNTERS(3),
    .SYNC_STAGES (0),
    .READBACK_EN (1'b1)
  ) u_dut_a (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .internal_data_bus(a_data),
    .write_control    (a_wc),
    .write_counter    (a_wcnt),
    .read_counter     (a_rdc),
    .read_done        (a_rdd),
    .latch_count      (a_lc),
    .latch_status     (a_ls)
  );

  kf8254_bus_interface #(
    .NUM_COUNTERS(2),
    .SYNC_STAGES (2),
    .READBACK_EN (1'b0)
  ) u_dut_b (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .internal_data_bus(b_data),
    .write_control    (b_wc),
    .write_counter    (b_wcnt),
    .read_counter     (b_rdc),
    .read_done        (b_rdd),
    .latch_count      (b_lc),
    .latch_status     (b_ls)
  );

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]  wc;
    logic [2:0]  wcnt;
    logic [2:0]  rdc;
    logic [2:0]  rdd;
    logic [2:0]  lc;
    logic [2:0]  ls;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    bit         is_rd;
    logic [1:0] a;
    logic [7:0] d;
    int         low;
    bit         cs_end;
    logic [2:0] awc, awcnt, alc, als, ard;
    logic [2:0] bwc, bwcnt, brd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  last_d = 8'h00;
  ev_t         qa[$];
  ev_t         qb[$];
  vec_t        vecs[12];

  always @(negedge clock) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int unsigned c, input logic [2:0] wc, input logic [2:0] wcnt,
                                input logic [2:0] rdc, input logic [2:0] rdd, input logic [2:0] lc,
                                input logic [2:0] ls, input logic [7:0] data);
    ev_t e;
    e.cyc = c; e.wc = wc; e.wcnt = wcnt; e.rdc = rdc; e.rdd = rdd; e.lc = lc; e.ls = ls;
    e.data = data;
    return e;
  endfunction

  task automatic cmp_ev(input string name, input ev_t got, input bit have, input ev_t exp);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected output: got cyc=%0d wc=%b wcnt=%b rdc=%b rdd=%b lc=%b ls=%b d=%h",
               name, got.cyc, got.wc, got.wcnt, got.rdc, got.rdd, got.lc, got.ls, got.data);
    end else if (got !== exp) begin
      errors++;
      $display("FAIL %s event: got cyc=%0d wc=%b wcnt=%b rdc=%b rdd=%b lc=%b ls=%b d=%h, %s",
               name, got.cyc, got.wc, got.wcnt, got.rdc, got.rdd, got.lc, got.ls, got.data,
               $sformatf("expected cyc=%0d wc=%b wcnt=%b rdc=%b rdd=%b lc=%b ls=%b d=%h",
                         exp.cyc, exp.wc, exp.wcnt, exp.rdc, exp.rdd, exp.lc, exp.ls, exp.data));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitors: any nonzero strobe/level pops the next expected event.
  always @(posedge clock) begin
    ev_t got, exp;
    bit  have;
    if (!reset && ((|a_wc) || (|a_wcnt) || (|a_rdc) || (|a_rdd) || (|a_lc) || (|a_ls))) begin
      got  = mk_ev(cyc, a_wc, a_wcnt, a_rdc, a_rdd, a_lc, a_ls, a_data);
      have = (qa.size() != 0);
      exp  = have ? qa.pop_front() : '0;
      cmp_ev("dut_a", got, have, exp);
    end
  end

  always @(posedge clock) begin
    ev_t got, exp;
    bit  have;
    if (!reset && ((|b_wc) || (|b_wcnt) || (|b_rdc) || (|b_rdd) || (|b_lc) || (|b_ls))) begin
      got  = mk_ev(cyc, {1'b0, b_wc}, {1'b0, b_wcnt}, {1'b0, b_rdc}, {1'b0, b_rdd},
                   {1'b0, b_lc}, {1'b0, b_ls}, b_data);
      have = (qb.size() != 0);
      exp  = have ? qb.pop_front() : '0;
      cmp_ev("dut_b", got, have, exp);
    end
  end

  task automatic idle_bus();
    bus.chip_select_n  = 1'b1;
    bus.read_enable_n  = 1'b1;
    bus.write_enable_n = 1'b1;
  endtask

  task automatic do_write(input vec_t v);
    int unsigned e0, k;
    @(posedge clock);
    bus.chip_select_n  = 1'b0;
    bus.write_enable_n = 1'b0;
    bus.address        = v.a;
    bus.data_bus_in    = v.d;
    last_d             = v.d;
    e0 = cyc + 1;
    k  = e0 + v.low;
    if ((|v.awc) || (|v.awcnt) || (|v.alc) || (|v.als))
      qa.push_back(mk_ev(k, v.awc, v.awcnt, 3'b0, 3'b0, v.alc, v.als, v.d));
    if ((|v.bwc) || (|v.bwcnt))
      qb.push_back(mk_ev(k + 2, v.bwc, v.bwcnt, 3'b0, 3'b0, 3'b0, 3'b0, v.d));
    repeat (v.low) @(posedge clock);
    if (v.cs_end) begin
      bus.chip_select_n = 1'b1;
      @(posedge clock);
    end
    idle_bus();
    repeat (3) @(posedge clock);
  endtask

  task automatic do_read(input vec_t v);
    int unsigned e0;
    @(posedge clock);
    bus.chip_select_n = 1'b0;
    bus.read_enable_n = 1'b0;
    bus.address       = v.a;
    e0 = cyc + 1;
    for (int j = 0; j < v.low; j++) begin
      if (|v.ard) qa.push_back(mk_ev(e0 + j, 3'b0, 3'b0, v.ard, 3'b0, 3'b0, 3'b0, last_d));
      if (|v.brd) qb.push_back(mk_ev(e0 + j + 2, 3'b0, 3'b0, v.brd, 3'b0, 3'b0, 3'b0, last_d));
    end
    if (|v.ard) qa.push_back(mk_ev(e0 + v.low, 3'b0, 3'b0, 3'b0, v.ard, 3'b0, 3'b0, last_d));
    if (|v.brd) qb.push_back(mk_ev(e0 + v.low + 2, 3'b0, 3'b0, 3'b0, v.brd, 3'b0, 3'b0, last_d));
    repeat (v.low) @(posedge clock);
    idle_bus();
    repeat (3) @(posedge clock);
  endtask

  function automatic logic [31:0] outs_a();
    return {a_data, 2'b0, a_wc, a_wcnt, a_rdc, a_rdd, a_lc, a_ls};
  endfunction

  function automatic logic [31:0] outs_b();
    return {b_data, 12'b0, b_wc, b_wcnt, b_rdc, b_rdd, b_lc, b_ls};
  endfunction

  initial begin
    vec_t clean;
    //          rd  A  D      low cs  a_wc    a_wcnt  a_lc    a_ls    a_rd    b_wc    b_wcnt  b_rd
    vecs[0]  = '{0, 3, 8'h34, 2, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[1]  = '{0, 2, 8'hA5, 1, 0, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{0, 3, 8'hDA, 1, 0, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{0, 3, 8'hCA, 1, 0, 3'b000, 3'b000, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{0, 3, 8'hE4, 1, 0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[5]  = '{0, 3, 8'h80, 1, 0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[6]  = '{0, 1, 8'h5A, 3, 1, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
    vecs[7]  = '{0, 0, 8'h0F, 1, 0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    vecs[8]  = '{1, 1, 8'h00, 3, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010};
    vecs[9]  = '{1, 3, 8'h00, 2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[10] = '{1, 2, 8'h00, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    vecs[11] = '{0, 3, 8'h76, 1, 0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};

    idle_bus();
    bus.address     = 2'b00;
    bus.data_bus_in = 8'h00;
    #3;
    chk("reset_outputs_a", outs_a(), 32'h0);
    chk("reset_outputs_b", outs_b(), 32'h0);
    repeat (3) @(posedge clock);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    chk("idle_outputs_a", outs_a(), 32'h0);
    chk("idle_outputs_b", outs_b(), 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].is_rd) do_read(vecs[i]);
      else do_write(vecs[i]);
    end

    // Reset lands during a write; the write must be dropped after release.
    @(posedge clock);
    bus.chip_select_n  = 1'b0;
    bus.write_enable_n = 1'b0;
    bus.address        = 2'b00;
    bus.data_bus_in    = 8'h11;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset_outputs_a", outs_a(), 32'h0);
    chk("midreset_outputs_b", outs_b(), 32'h0);
    @(posedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    idle_bus();
    repeat (6) @(posedge clock);

    clean = '{0, 0, 8'h22, 1, 0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    do_write(clean);

    repeat (10) @(posedge clock);
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL dut_a missing events: got %0d outstanding expected 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL dut_b missing events: got %0d outstanding expected 0", qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
